// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel valid/ready arbiter feeding a single registered output
// stage. Arbitration is either fixed priority (lowest index wins) or round
// robin from a rotating pointer. The output register reloads on the same edge
// it drains, so a continuously ready consumer sees one word per cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   mode       0 = fixed priority, 1 = round robin
//   in_data    packed channel words, channel i at [i*inputSize +: inputSize]
//   in_valid   per-channel offer
//   in_ready   one-hot accept strobe for the winning channel (combinational)
//   out_data   registered selected word
//   out_valid  out_data holds an unconsumed word
//   out_ready  downstream accepts out_data
//   out_sel    index of the channel that supplied out_data
module rr_arb_mux #(
    parameter int unsigned inputSize = 16,
    parameter int unsigned channels  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              mode,
    input  logic [channels*inputSize-1:0]     in_data,
    input  logic [channels-1:0]               in_valid,
    output logic [channels-1:0]               in_ready,
    output logic [inputSize-1:0]              out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [$clog2(channels)-1:0]       out_sel
);

    localparam int unsigned selSize = $clog2(channels);
    // One extra bit so base + offset never overflows before the wrap subtract.
    localparam int unsigned cntSize = selSize + 1;

    logic [selSize-1:0]   ptr;
    logic                 load_c;
    logic                 found_c;
    logic                 accept_c;
    logic [selSize-1:0]   gnt_c;
    logic [selSize-1:0]   idx_c;
    logic [cntSize-1:0]   pos_c;
    logic [inputSize-1:0] gnt_data_c;
    logic [selSize-1:0]   ptr_next_c;

    // Output slot is free or being emptied this cycle.
    assign load_c = ~out_valid | out_ready;

    // Search upward from the base (ptr in round robin, 0 in fixed priority),
    // wrapping at channels-1; first valid channel wins.
    always_comb begin
        found_c = 1'b0;
        gnt_c   = '0;
        pos_c   = '0;
        idx_c   = '0;
        for (int k = 0; k < channels; k++) begin
            pos_c = cntSize'(mode ? ptr : '0) + cntSize'(k);
            if (pos_c >= cntSize'(channels)) begin
                pos_c = pos_c - cntSize'(channels);
            end
            idx_c = selSize'(pos_c);
            if (!found_c && in_valid[idx_c]) begin
                found_c = 1'b1;
                gnt_c   = idx_c;
            end
        end
    end

    // Data mux for the winning channel.
    always_comb begin
        gnt_data_c = '0;
        for (int k = 0; k < channels; k++) begin
            if (gnt_c == selSize'(k)) begin
                gnt_data_c = in_data[k*inputSize +: inputSize];
            end
        end
    end

    assign accept_c   = ~rst & load_c & found_c;
    assign in_ready   = accept_c ? (channels'(1) << gnt_c) : '0;
    assign ptr_next_c = (gnt_c == selSize'(channels - 1)) ? '0 : gnt_c + selSize'(1);

    // Output register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (accept_c) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data_c;
            out_sel   <= gnt_c;
            if (mode) begin
                ptr <= ptr_next_c;
            end
        end else if (out_ready) begin
            // Drained with nothing to refill: data/sel are kept.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux (4 channels x 16 bits).
module tb_rr_arb_mux;

    localparam int unsigned W = 16;
    localparam int unsigned N = 4;

    logic           clk;
    logic           rst;
    logic           mode;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic [1:0]     out_sel;

    int total;
    int bad;

    logic [W-1:0] chd [N];

    rr_arb_mux #(.inputSize(W), .channels(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sel   (out_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = '0; out_ready = 1'b1; mode = 1'b0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 1'b0; in_valid = 4'b1111; out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 4'b0000) begin bad++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
        tick();
        tick();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++;
        if (out_data !== 16'h0000) begin bad++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
        total++;
        if (out_sel !== 2'd0) begin bad++; $display("FAIL reset_out_sel got=%0d exp=0", out_sel); end
        rst = 1'b0; in_valid = '0;
        #1;
    endtask

    task automatic test_fixed_priority();
        do_reset();
        mode = 1'b0; out_ready = 1'b1; in_valid = 4'b1010;
        #1;
        total++;
        if (in_ready !== 4'b0010) begin bad++; $display("FAIL fp_in_ready got=%b exp=0010", in_ready); end
        tick();
        total++;
        if (out_data !== 16'h1111 || out_sel !== 2'd1 || out_valid !== 1'b1) begin
            bad++; $display("FAIL fp_out got=%h/%0d/%b exp=1111/1/1", out_data, out_sel, out_valid);
        end
        in_valid = 4'b1100;
        #1;
        total++;
        if (in_ready !== 4'b0100) begin bad++; $display("FAIL fp_in_ready2 got=%b exp=0100", in_ready); end
        tick();
        total++;
        if (out_data !== 16'h2222 || out_sel !== 2'd2) begin
            bad++; $display("FAIL fp_out2 got=%h/%0d exp=2222/2", out_data, out_sel);
        end
        in_valid = '0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_rdy;
        do_reset();
        mode = 1'b1; out_ready = 1'b1; in_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            #1;
            exp_rdy = 4'b0001 << (i % 4);
            total++;
            if (in_ready !== exp_rdy) begin bad++; $display("FAIL rr_in_ready[%0d] got=%b exp=%b", i, in_ready, exp_rdy); end
            tick();
            total++;
            if (out_sel !== 2'(i % 4) || out_data !== chd[i % 4] || out_valid !== 1'b1) begin
                bad++; $display("FAIL rr_out[%0d] got=%0d/%h exp=%0d/%h", i, out_sel, out_data, i % 4, chd[i % 4]);
            end
        end
        in_valid = '0;
        tick();
    endtask

    // Leaves pointer at 2.
    task automatic test_backpressure();
        do_reset();
        mode = 1'b1; out_ready = 1'b1; in_valid = 4'b1111;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (in_ready !== 4'b0000) begin bad++; $display("FAIL bp_in_ready[%0d] got=%b exp=0000", i, in_ready); end
            tick();
            total++;
            if (out_data !== 16'h0F0F || out_sel !== 2'd0 || out_valid !== 1'b1) begin
                bad++; $display("FAIL bp_hold[%0d] got=%h/%0d/%b exp=0f0f/0/1", i, out_data, out_sel, out_valid);
            end
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 4'b0010) begin bad++; $display("FAIL bp_release_ready got=%b exp=0010", in_ready); end
        tick();
        in_valid = '0;
        total++;
        if (out_data !== 16'h1111 || out_sel !== 2'd1 || out_valid !== 1'b1) begin
            bad++; $display("FAIL bp_release_out got=%h/%0d/%b exp=1111/1/1", out_data, out_sel, out_valid);
        end
        tick();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_single_load got=%b exp=0", out_valid); end
    endtask

    // Expects pointer at 2 on entry; leaves it at 1.
    task automatic test_wrap();
        mode = 1'b1; out_ready = 1'b1; in_valid = 4'b0100;
        tick();
        in_valid = 4'b1001;
        #1;
        total++;
        if (in_ready !== 4'b1000) begin bad++; $display("FAIL wrap_ready3 got=%b exp=1000", in_ready); end
        tick();
        total++;
        if (out_sel !== 2'd3 || out_data !== 16'h3333) begin
            bad++; $display("FAIL wrap_out3 got=%0d/%h exp=3/3333", out_sel, out_data);
        end
        total++;
        if (in_ready !== 4'b0001) begin bad++; $display("FAIL wrap_ready0 got=%b exp=0001", in_ready); end
        tick();
        total++;
        if (out_sel !== 2'd0 || out_data !== 16'h0F0F) begin
            bad++; $display("FAIL wrap_out0 got=%0d/%h exp=0/0f0f", out_sel, out_data);
        end
        in_valid = '0;
        tick();
    endtask

    // Expects pointer at 1 on entry; leaves it at 2.
    task automatic test_mode_change();
        mode = 1'b1; out_ready = 1'b1; in_valid = 4'b0101;
        #1;
        total++;
        if (in_ready !== 4'b0100) begin bad++; $display("FAIL mc_rr_ready got=%b exp=0100", in_ready); end
        mode = 1'b0;
        #1;
        total++;
        if (in_ready !== 4'b0001) begin bad++; $display("FAIL mc_fp_ready got=%b exp=0001", in_ready); end
        tick();
        total++;
        if (out_sel !== 2'd0) begin bad++; $display("FAIL mc_fp_out got=%0d exp=0", out_sel); end
        mode = 1'b1; in_valid = 4'b0011;
        #1;
        total++;
        if (in_ready !== 4'b0010) begin bad++; $display("FAIL mc_ptr_kept got=%b exp=0010", in_ready); end
        tick();
        total++;
        if (out_sel !== 2'd1 || out_data !== 16'h1111) begin
            bad++; $display("FAIL mc_rr_out got=%0d/%h exp=1/1111", out_sel, out_data);
        end
        in_valid = '0;
        tick();
    endtask

    // Expects pointer at 2 on entry.
    task automatic test_reset_midstream();
        mode = 1'b1; out_ready = 1'b0; in_valid = 4'b1111;
        tick();
        total++;
        if (out_valid !== 1'b1 || out_sel !== 2'd2) begin
            bad++; $display("FAIL rm_preload got=%b/%0d exp=1/2", out_valid, out_sel);
        end
        rst = 1'b1; out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 4'b0000) begin bad++; $display("FAIL rm_in_ready got=%b exp=0000", in_ready); end
        tick();
        rst = 1'b0;
        total++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_sel !== 2'd0) begin
            bad++; $display("FAIL rm_cleared got=%b/%h/%0d exp=0/0000/0", out_valid, out_data, out_sel);
        end
        #1;
        total++;
        if (in_ready !== 4'b0001) begin bad++; $display("FAIL rm_ptr_zero got=%b exp=0001", in_ready); end
        tick();
        in_valid = '0;
        total++;
        if (out_sel !== 2'd0 || out_data !== 16'h0F0F || out_valid !== 1'b1) begin
            bad++; $display("FAIL rm_after got=%0d/%h/%b exp=0/0f0f/1", out_sel, out_data, out_valid);
        end
        tick();
    endtask

    task automatic test_drain();
        do_reset();
        mode = 1'b0; out_ready = 1'b1; in_valid = 4'b0100;
        tick();
        in_valid = '0;
        total++;
        if (out_valid !== 1'b1 || out_data !== 16'h2222) begin
            bad++; $display("FAIL dr_load got=%b/%h exp=1/2222", out_valid, out_data);
        end
        tick();
        total++;
        if (out_valid !== 1'b0 || out_data !== 16'h2222 || out_sel !== 2'd2) begin
            bad++; $display("FAIL dr_empty got=%b/%h/%0d exp=0/2222/2", out_valid, out_data, out_sel);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        chd[0] = 16'h0F0F;
        chd[1] = 16'h1111;
        chd[2] = 16'h2222;
        chd[3] = 16'h3333;
        in_data   = {chd[3], chd[2], chd[1], chd[0]};
        rst       = 1'b1;
        mode      = 1'b0;
        in_valid  = '0;
        out_ready = 1'b1;
        tick();
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_mode_change();
        test_reset_midstream();
        test_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux.md
RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 SHALL have parameter inputSize, default 16, giving the data width of each channel and of the output.
REQ-002 SHALL have parameter channels, default 4, giving the number of input channels; legal range 2..16.
REQ-003 SHALL derive localparam selSize = clog2(channels), the width of the grant index.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port mode, input, 1 bit: 0 = fixed priority (lowest index wins), 1 = round robin.
REQ-007 SHALL have port in_data, input, channels*inputSize bits: channel i occupies bits [i*inputSize +: inputSize].
REQ-008 SHALL have port in_valid, input, channels bits: channel i offers a word.
REQ-009 SHALL have port in_ready, output, channels bits: channel i's word is accepted this cycle.
REQ-010 SHALL have port out_data, output, inputSize bits: registered selected word.
REQ-011 SHALL have port out_valid, output, 1 bit: out_data holds an unconsumed word.
REQ-012 SHALL have port out_ready, input, 1 bit: the downstream consumer accepts out_data.
REQ-013 SHALL have port out_sel, output, selSize bits: index of the channel that supplied the current out_data.

Function
REQ-014 SHALL treat a transfer on either side as occurring only on a cycle where valid and ready are both high at the rising edge.
REQ-015 SHALL compute load = ~out_valid | out_ready, meaning the single output register is empty or is being drained this cycle.
REQ-016 SHALL drive in_ready as one-hot on the winning channel when load=1 and any in_valid is set, and all-zero otherwise; in_ready is combinational from in_valid, mode, the pointer, out_valid and out_ready.
REQ-017 SHALL, in fixed-priority mode, select the lowest-indexed channel with in_valid=1.
REQ-018 SHALL, in round-robin mode, select the first channel with in_valid=1 searching upward from ptr with wrap from channels-1 to 0.
REQ-019 SHALL, on an accepted input from channel g, register out_data = channel g data, out_sel = g and out_valid = 1 on the next edge (1-cycle latency).
REQ-020 SHALL, on an accepted input from channel g, update ptr to (g+1) mod channels; when g = channels-1, ptr SHALL wrap to 0.
REQ-021 SHALL leave ptr unchanged in fixed-priority mode and on cycles with no accepted input.
REQ-022 SHALL, when out_valid=1 and out_ready=1 and no channel is valid, clear out_valid on the next edge while out_data and out_sel hold their values.
REQ-023 SHALL, when out_valid=1 and out_ready=0, hold out_data, out_sel and out_valid stable and drive in_ready = 0 (backpressure).
REQ-024 SHALL, on simultaneous drain and load, replace the output word in the same edge with no bubble, sustaining 1 word/cycle.
REQ-025 SHALL apply a mode change at any time, taking effect for the arbitration decision in the same cycle; ptr SHALL keep its value across mode changes.
REQ-026 SHALL never accept more than one input per cycle, and SHALL never lose or duplicate an accepted word.
REQ-027 SHALL give no channel more than channels-1 consecutive losses while it is continuously valid in round-robin mode with out_ready held at 1.

Reset
REQ-028 SHALL, on an edge with rst=1, set out_valid=0, out_data=0, out_sel=0 and ptr=0, overriding any concurrent transfer.
REQ-029 SHALL drive in_ready = 0 while rst=1, so that no input is accepted during reset.
REQ-030 SHALL discard a word held in the output register when rst is asserted mid-operation; it SHALL not reappear after reset.

Verification
REQ-031 SHALL cover fixed priority: mode=0, in_valid=4'b1010, out_ready=1, ch1=16'h1111, ch3=16'h3333 -> in_ready=4'b0010; next cycle out_data=16'h1111, out_sel=1.
REQ-032 SHALL cover round robin: mode=1, all four channels valid for 8 cycles, out_ready=1 -> out_sel sequence 0,1,2,3,0,1,2,3 after reset.
REQ-033 SHALL cover backpressure: out_valid=1, out_ready=0 for 3 cycles with in_valid=4'b1111 -> in_ready=0 and out_data unchanged throughout; on release, exactly one new word loads.
REQ-034 SHALL cover wrap: mode=1, ptr=3, in_valid=4'b1001 -> channel 3 granted, ptr becomes 0; next grant goes to channel 0.
REQ-035 SHALL cover reset mid-stream: rst asserted for 1 cycle while out_valid=1 -> out_valid=0, out_data=0, ptr=0 on the next cycle, with in_ready=0 during the reset cycle.
REQ-036 SHALL cover drain without refill: out_valid=1, out_ready=1, in_valid=0 -> out_valid=0 on the next edge, with out_data held.
